// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one SRAM port between NumReq requesters that all speak the SRAM
// req/gnt/addr/wdata/strb/we protocol. One requester is selected per cycle
// with zero-cycle request-to-grant latency. The response is steered back
// through a one-hot rvalid_o one cycle after each transfer. A requester can
// hold the port for up to MaxLock consecutive transfers by raising lock_i.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin among non-owners
//                           undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, lock_i       per-requester request and lock request
//   addr_i, wdata_i,
//   strb_i, we_i        per-requester transfer fields
//   gnt_o               one-hot grant (transfer when req_i[k] && gnt_o[k])
//   rvalid_o            one-hot response valid, one cycle after transfer
//   rdata_o             response data, shared (mem_rdata_i passed through)
//   mem_req_o..mem_we_o SRAM request side
//   mem_gnt_i           SRAM grant
//   mem_rdata_i         SRAM read data, one cycle after an accepted request
module mem_port_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StrbWidth = DataWidth / 8,
  parameter int unsigned MaxLock   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   lock_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0]    strb_i,
  input  logic [NumReq-1:0]                   we_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                mem_req_o,
  input  logic                                mem_gnt_i,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [StrbWidth-1:0]                mem_strb_o,
  output logic                                mem_we_o,
  input  logic [DataWidth-1:0]                mem_rdata_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] LockLimit = CntW'(MaxLock);

  // Lock state
  logic            owner_vld_q;
  logic [IdxW-1:0] owner_q;
  logic [CntW-1:0] lock_cnt_q;
  logic [CntW-1:0] cnt_nxt;
  logic            lock_hold;
  logic            owner_active;

  // Stall freeze
  logic            stall_q;
  logic [IdxW-1:0] stall_sel_q;

  // Response steering
  logic [NumReq-1:0] resp_sel_q;

  // Selection
  logic            any_req;
  logic            found;
  logic [IdxW-1:0] arb_sel;
  logic [IdxW-1:0] sel;
  logic            mem_req;
  logic            xfer;
  logic [NumReq-1:0] gnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] rr_ptr_q;
  int unsigned     cand;
`endif

  assign any_req      = |req_i;
  assign owner_active = owner_vld_q && req_i[owner_q];

  // Policy arbitration among all requesters; the owner and the stall
  // freeze override it below.
  always_comb begin
    arb_sel = '0;
    found   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    cand = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(rr_ptr_q) + i) % NumReq;
      if (!found && req_i[IdxW'(cand)]) begin
        found   = 1'b1;
        arb_sel = IdxW'(cand);
      end
    end
`else
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_i[IdxW'(i)]) begin
        found   = 1'b1;
        arb_sel = IdxW'(i);
      end
    end
`endif
  end

  // A stalled request keeps its slot even if a higher-priority requester or
  // the lock owner shows up before the SRAM grants it.
  always_comb begin
    if (stall_q) begin
      sel = stall_sel_q;
    end else if (owner_active) begin
      sel = owner_q;
    end else begin
      sel = arb_sel;
    end
  end

  assign mem_req = !rst_i && any_req;
  assign xfer    = mem_req && mem_gnt_i && req_i[sel];

  always_comb begin
    gnt = '0;
    if (xfer) begin
      gnt[sel] = 1'b1;
    end
  end

  assign gnt_o     = gnt;
  assign mem_req_o = mem_req;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    mem_we_o    = 1'b0;
    if (mem_req) begin
      mem_addr_o  = addr_i[sel];
      mem_wdata_o = wdata_i[sel];
      mem_strb_o  = strb_i[sel];
      mem_we_o    = we_i[sel];
    end
  end

  // Reset in the response cycle swallows the pending pulse.
  assign rvalid_o = rst_i ? '0 : resp_sel_q;
  assign rdata_o  = mem_rdata_i;

  // Count of consecutive locked transfers including the current one. The
  // transfer that reaches MaxLock releases the lock straight away, so the
  // owner's next request goes through normal arbitration.
  always_comb begin
    cnt_nxt = CntW'(1);
    if (owner_vld_q && (owner_q == sel)) begin
      cnt_nxt = lock_cnt_q + CntW'(1);
    end
  end

  assign lock_hold = (cnt_nxt < LockLimit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      stall_q     <= 1'b0;
      stall_sel_q <= '0;
      resp_sel_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      resp_sel_q <= gnt;

      if (mem_req && !mem_gnt_i) begin
        stall_q     <= 1'b1;
        stall_sel_q <= sel;
      end else begin
        stall_q     <= 1'b0;
      end

      if (xfer) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_ptr_q <= (32'(sel) == NumReq - 1) ? '0 : sel + IdxW'(1);
`endif
        if (lock_i[sel] && lock_hold) begin
          owner_vld_q <= 1'b1;
          owner_q     <= sel;
          lock_cnt_q  <= cnt_nxt;
        end else begin
          owner_vld_q <= 1'b0;
          lock_cnt_q  <= '0;
        end
      end else if (owner_vld_q && !req_i[owner_q]) begin
        owner_vld_q <= 1'b0;
        lock_cnt_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (NumReq=2, MaxLock=4).
// Expected grant sequences depend on MEM_ARB_ROUND_ROBIN_EN and are chosen
// with the same macro.
module tb_mem_port_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       lock;
  logic [1:0][63:0] addr;
  logic [1:0][63:0] wdata;
  logic [1:0][7:0]  strb;
  logic [1:0]       we;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [63:0]      rdata;
  logic             mem_req;
  logic             mem_gnt;
  logic [63:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_strb;
  logic             mem_we;
  logic [63:0]      mem_rdata;

  int unsigned n_chk;
  int unsigned n_fail;
  logic [1:0]  prev_gnt;

  mem_port_arbiter #(
    .NumReq   (2),
    .AddrWidth(64),
    .DataWidth(64),
    .StrbWidth(8),
    .MaxLock  (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .lock_i     (lock),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .strb_i     (strb),
    .we_i       (we),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .mem_req_o  (mem_req),
    .mem_gnt_i  (mem_gnt),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_strb_o (mem_strb),
    .mem_we_o   (mem_we),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, drive the inputs, let them settle, then check the
  // previous cycle's response and this cycle's grant.
  task automatic run(input string tag, input logic r, input logic [1:0] rq,
                     input logic [1:0] lk, input logic g, input logic [1:0] exp_gnt);
    @(posedge clk);
    #1;
    rst     = r;
    req     = rq;
    lock    = lk;
    mem_gnt = g;
    #4;
    check({tag, "_rvalid"}, 64'(rvalid), 64'(prev_gnt));
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    prev_gnt = exp_gnt;
  endtask

  logic [1:0] sim_seq [4];
  logic [1:0] stall_tail;
  logic [1:0] lock_seq [8];

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    prev_gnt = 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    sim_seq  = '{2'b01, 2'b10, 2'b01, 2'b10};
    stall_tail = 2'b10;
    lock_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
`else
    sim_seq  = '{2'b01, 2'b01, 2'b01, 2'b01};
    stall_tail = 2'b01;
    lock_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset values
    rst       = 1'b1;
    req       = 2'b11;
    lock      = 2'b00;
    we        = 2'b11;
    addr[0]   = 64'h100;
    addr[1]   = 64'h200;
    wdata[0]  = 64'hAAAA_0000_0000_0001;
    wdata[1]  = 64'hBBBB_0000_0000_0002;
    strb[0]   = 8'h0F;
    strb[1]   = 8'hF0;
    mem_gnt   = 1'b1;
    mem_rdata = 64'h1234;
    #4;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_mem_strb", 64'(mem_strb), 64'h0);
    check("rst_rdata", rdata, 64'h1234);
    run("rst2", 1'b1, 2'b11, 2'b00, 1'b1, 2'b00);
    we = 2'b00;

    // Simultaneous requests, no stall
    for (int i = 0; i < 4; i++) begin
      run("sim", 1'b0, 2'b11, 2'b00, 1'b1, sim_seq[i]);
      check("sim_addr", mem_addr, sim_seq[i][0] ? 64'h100 : 64'h200);
    end
    run("sim_idle", 1'b0, 2'b00, 2'b00, 1'b1, 2'b00);
    check("idle_mem_req", 64'(mem_req), 64'h0);

    // Stall with requester 0 pending, requester 1 arrives later
    for (int i = 0; i < 3; i++) begin
      run("stallA", 1'b0, 2'b01, 2'b00, 1'b0, 2'b00);
      check("stallA_mem_req", 64'(mem_req), 64'h1);
      check("stallA_addr", mem_addr, 64'h100);
    end
    run("stallA_both", 1'b0, 2'b11, 2'b00, 1'b0, 2'b00);
    check("stallA_both_addr", mem_addr, 64'h100);
    run("stallA_go", 1'b0, 2'b11, 2'b00, 1'b1, 2'b01);
    run("stallA_tail", 1'b0, 2'b11, 2'b00, 1'b1, stall_tail);
    run("stallA_idle", 1'b0, 2'b00, 2'b00, 1'b1, 2'b00);

    // Stall with requester 1 pending; requester 0 must not steal the slot
    run("stallB", 1'b0, 2'b10, 2'b00, 1'b0, 2'b00);
    run("stallB", 1'b0, 2'b10, 2'b00, 1'b0, 2'b00);
    run("stallB_both", 1'b0, 2'b11, 2'b00, 1'b0, 2'b00);
    check("stallB_both_addr", mem_addr, 64'h200);
    run("stallB_go", 1'b0, 2'b11, 2'b00, 1'b1, 2'b10);
    check("stallB_go_addr", mem_addr, 64'h200);
    run("stallB_idle", 1'b0, 2'b00, 2'b00, 1'b1, 2'b00);

    // Read by requester 0, then write by requester 1
    addr[0] = 64'h10;
    addr[1] = 64'h18;
    run("rd", 1'b0, 2'b01, 2'b00, 1'b1, 2'b01);
    check("rd_we", 64'(mem_we), 64'h0);
    check("rd_addr", mem_addr, 64'h10);
    we        = 2'b10;
    mem_rdata = 64'hDEADBEEF_00C0FFEE;
    run("wr", 1'b0, 2'b10, 2'b00, 1'b1, 2'b10);
    check("rd_rdata", rdata, 64'hDEADBEEF_00C0FFEE);
    check("wr_we", 64'(mem_we), 64'h1);
    check("wr_addr", mem_addr, 64'h18);
    check("wr_wdata", mem_wdata, 64'hBBBB_0000_0000_0002);
    check("wr_strb", 64'(mem_strb), 64'hF0);
    we = 2'b00;
    run("wr_idle", 1'b0, 2'b00, 2'b00, 1'b1, 2'b00);

    // Lock limit: requester 1 locks alone first, then requester 0 joins
    run("lock0", 1'b0, 2'b10, 2'b10, 1'b1, lock_seq[0]);
    for (int i = 1; i < 8; i++) begin
      run("lock", 1'b0, 2'b11, 2'b10, 1'b1, lock_seq[i]);
    end
    run("lock_idle", 1'b0, 2'b00, 2'b00, 1'b1, 2'b00);

    // Reset in the cycle after a transfer
    run("pre_rst", 1'b0, 2'b01, 2'b00, 1'b1, 2'b01);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    req     = 2'b11;
    mem_gnt = 1'b1;
    #4;
    check("rst_xfer_rvalid", 64'(rvalid), 64'h0);
    check("rst_xfer_gnt", 64'(gnt), 64'h0);
    check("rst_xfer_mem_req", 64'(mem_req), 64'h0);
    check("rst_xfer_addr", mem_addr, 64'h0);
    prev_gnt = 2'b00;
    run("post_rst", 1'b0, 2'b11, 2'b00, 1'b1, 2'b01);
    run("post_rst_idle", 1'b0, 2'b00, 2'b00, 1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 64-bit SRAM port of the tiny SoC between up to `NumReq` memory requesters (core memory port, debug/loader port, DMA-style test injectors). Each requester speaks the same req/gnt/addr/wdata/strb/we protocol the SRAM port speaks. The SRAM returns read data one cycle after an accepted request. The arbiter selects one requester per cycle and routes the response back through a one-hot `rvalid_o`. It supports short locked sequences for read-modify-write and sits directly between the requesters and the `noift_sram_mem` instance.

## Interface
- `NumReq`, 2, number of requesters (2..8)
- `AddrWidth`, 64, address width
- `DataWidth`, 64, data width
- `StrbWidth`, `DataWidth/8`, byte-strobe width
- `MaxLock`, 4, maximum consecutive locked transfers by one requester (1..15)

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `req_i`  in  NumReq  per-requester request
- `lock_i`  in  NumReq  request that the next transfer also go to this requester
- `addr_i`  in  NumReq x AddrWidth  per-requester byte address
- `wdata_i`  in  NumReq x DataWidth  per-requester write data
- `strb_i`  in  NumReq x StrbWidth  per-requester byte strobes
- `we_i`  in  NumReq  per-requester write enable
- `gnt_o`  out  NumReq  one-hot grant; transfer occurs when `req_i[k] && gnt_o[k]`
- `rvalid_o`  out  NumReq  one-hot response valid
- `rdata_o`  out  DataWidth  response data, shared by all requesters
- `mem_req_o`  out  1  SRAM request
- `mem_gnt_i`  in  1  SRAM grant
- `mem_addr_o`  out  AddrWidth  SRAM address
- `mem_wdata_o`  out  DataWidth  SRAM write data
- `mem_strb_o`  out  StrbWidth  SRAM byte strobes
- `mem_we_o`  out  1  SRAM write enable
- `mem_rdata_i`  in  DataWidth  SRAM read data, valid one cycle after an accepted request

## Operation
- Selection happens in the same cycle as the request. When any `req_i` is set, `mem_req_o`=1 and the `mem_*` outputs mux the selected requester's fields.
- `gnt_o[sel] = mem_gnt_i`. All other grant bits are 0.
- **Stall.** While `mem_req_o && !mem_gnt_i`, the selection is frozen in a `stall_q` register.
  - A newly arriving higher-priority request does not change `sel` until the pending request transfers.
  - Requesters must hold `req_i` and their fields stable until granted.
- **Priority order.** The lock owner comes first (see Lock). The remaining requesters are ordered by the policy under Configuration.
- **Lock.**
  - A transfer by k with `lock_i[k]`=1 sets `owner_q`=k and increments `lock_cnt_q`.
  - While `owner_q` is valid and `req_i[owner_q]`=1, the owner wins regardless of pointer.
  - The lock is released when the owner transfers with `lock_i`=0, when it drops `req_i`, or when `lock_cnt_q` reaches `MaxLock`.
  - At the `MaxLock` limit, the owner's next request arbitrates normally and `lock_cnt_q` clears.
- **Response.** Every transfer, read or write, produces exactly one `rvalid_o[k]` pulse one cycle later. For writes, `rdata_o` content is don't-care.
- `rdata_o` = `mem_rdata_i`, passed combinationally.
- Back-to-back transfers give back-to-back `rvalid_o` pulses, possibly to different requesters.

## Timing
- Request to grant: 0 cycles when `mem_gnt_i`=1.
- Grant to `rvalid_o`: 1 cycle, via the registered `resp_sel_q` one-hot.
- Throughput: one transfer per cycle.
- Reset values: `gnt_o`=0, `rvalid_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`/`mem_wdata_o`/`mem_strb_o`=0, `rdata_o` follows `mem_rdata_i`.
- Internal state after reset: `rr_ptr_q`=0, `owner_q` invalid, `lock_cnt_q`=0, `stall_q` clear, `resp_sel_q`=0.
- Reset in the cycle after a transfer suppresses that transfer's `rvalid_o`. Reset during a stall clears the frozen selection.
- `NumReq`=1 degenerates to a pass-through with one cycle `rvalid_o`. Lock still counts but has no visible effect.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin among non-owners, searching from `rr_ptr_q`.
  - After a transfer by k, `rr_ptr_q` = (k+1) mod `NumReq`.
  - `rr_ptr_q` is unchanged on stall or idle.
- Not defined:
  - Fixed priority: the lowest index wins.
  - `rr_ptr_q` is not implemented; lock behaviour is unchanged.

## Test plan
- **Simultaneous requests, round-robin, no stall.** Round-robin enabled, `req_i`=2'b11 for 4 cycles, `mem_gnt_i`=1 → grants alternate 01,10,01,10, `rvalid_o` follows one cycle later with the same sequence.
- **Simultaneous requests, fixed priority.** Same stimulus with the macro undefined → `gnt_o`=01 every cycle, requester 1 starved.
- **Stall.** `mem_gnt_i`=0 for 3 cycles with `req_i`=01, then `req_i`=11 → `mem_addr_o` stays requester 0's address, `gnt_o`=0 while stalled, and requester 0 is granted first when `mem_gnt_i` rises.
- **Lock limit.** `MaxLock`=4, requester 1 holds `req_i` and `lock_i` for 8 cycles with requester 0 also requesting → requester 1 gets 4 consecutive grants, then requester 0 gets one grant, then requester 1 regains the lock.
- **Read then write.** Read of addr 0x10 returning 0xDEADBEEF_00C0FFEE, then a write to 0x18 by requester 1 → `rvalid_o`=01 with `rdata_o`=0xDEADBEEF_00C0FFEE, then `rvalid_o`=10.
- **Reset after a transfer.** Assert `rst_i` in the cycle after a transfer → no `rvalid_o` pulse, all outputs at their reset values, and arbitration restarts from requester 0.
